// File: rtl/multiplica_colunas_seq.sv
// multiplica_colunas_seq
// Sequential AES column mixer. Applies MixColumns (inversa=0) or
// InvMixColumns (inversa=1) to a 128-bit row-major state, working on
// COLUNAS_POR_CICLO columns per clock (1, 2 or 4).
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous reset, active high
//   entrada_valida  bloco/inversa valid this cycle
//   entrada_pronta  unit can accept a block (OCIOSO)
//   bloco[127:0]    input state; byte k at [127-8k -: 8], column j = bytes j,j+4,j+8,j+12
//   inversa         mode, sampled together with bloco
//   saida_valida    saida holds a finished result (ENTREGA)
//   saida_pronta    consumer accepts saida this cycle
//   saida[127:0]    result state, same layout as bloco
//   ocupado         high in CALCULA or ENTREGA
//
// state   | meaning
// --------+-----------------------------------------------------------
// OCIOSO  | idle, waiting for a block; entrada_pronta=1
// CALCULA | mixing one column group per cycle, counter advances by N
// ENTREGA | result held on saida with saida_valida=1 until accepted

module multiplica_colunas_seq #(
  parameter int COLUNAS_POR_CICLO = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         entrada_valida,
  output logic         entrada_pronta,
  input  logic [127:0] bloco,
  input  logic         inversa,
  output logic         saida_valida,
  input  logic         saida_pronta,
  output logic [127:0] saida,
  output logic         ocupado
);

  if (!(COLUNAS_POR_CICLO == 1 || COLUNAS_POR_CICLO == 2 || COLUNAS_POR_CICLO == 4))
  begin : g_param_invalido
    $error("COLUNAS_POR_CICLO must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  estado_t        estado_q, estado_d;
  logic [127:0]   dados_q, dados_d;
  logic           inversa_q, inversa_d;
  logic [1:0]     contador_q, contador_d;
  logic [2:0]     soma_contador;
  logic [127:0]   dados_misturados;

  // GF(2^8) helpers, reduction polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul_02(input logic [7:0] a);
    return xtime(a);
  endfunction

  function automatic logic [7:0] mul_03(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] mul_09(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul_0b(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] mul_0d(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul_0e(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // Column packed as {a0,a1,a2,a3}, a0 = top row
  function automatic logic [31:0] mix_coluna(input logic [31:0] c, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    if (inv) begin
      b0 = mul_0e(a0) ^ mul_0b(a1) ^ mul_0d(a2) ^ mul_09(a3);
      b1 = mul_09(a0) ^ mul_0e(a1) ^ mul_0b(a2) ^ mul_0d(a3);
      b2 = mul_0d(a0) ^ mul_09(a1) ^ mul_0e(a2) ^ mul_0b(a3);
      b3 = mul_0b(a0) ^ mul_0d(a1) ^ mul_09(a2) ^ mul_0e(a3);
    end else begin
      b0 = mul_02(a0) ^ mul_03(a1) ^ a2 ^ a3;
      b1 = a0 ^ mul_02(a1) ^ mul_03(a2) ^ a3;
      b2 = a0 ^ a1 ^ mul_02(a2) ^ mul_03(a3);
      b3 = mul_03(a0) ^ a1 ^ a2 ^ mul_02(a3);
    end
    return {b0, b1, b2, b3};
  endfunction

  // Replace columns cnt..cnt+N-1 of s with their mixed values
  function automatic logic [127:0] mistura_grupo(input logic [127:0] s,
                                                 input logic [1:0]   cnt,
                                                 input logic         inv);
    logic [127:0] r;
    logic [31:0]  c;
    logic [31:0]  m;
    int           j;
    r = s;
    for (int i = 0; i < COLUNAS_POR_CICLO; i++) begin
      j = (int'(cnt) + i) % 4;
      for (int lin = 0; lin < 4; lin++) begin
        c[31-8*lin -: 8] = s[127-8*(j+4*lin) -: 8];
      end
      m = mix_coluna(c, inv);
      for (int lin = 0; lin < 4; lin++) begin
        r[127-8*(j+4*lin) -: 8] = m[31-8*lin -: 8];
      end
    end
    return r;
  endfunction

  // Carry out of the 2-bit counter marks the last column group
  assign soma_contador    = {1'b0, contador_q} + 3'(COLUNAS_POR_CICLO);
  assign dados_misturados = mistura_grupo(dados_q, contador_q, inversa_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= OCIOSO;
      dados_q    <= 128'h0;
      inversa_q  <= 1'b0;
      contador_q <= 2'd0;
    end else begin
      estado_q   <= estado_d;
      dados_q    <= dados_d;
      inversa_q  <= inversa_d;
      contador_q <= contador_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    dados_d    = dados_q;
    inversa_d  = inversa_q;
    contador_d = contador_q;
    case (estado_q)
      OCIOSO: begin
        if (entrada_valida) begin
          dados_d    = bloco;
          inversa_d  = inversa;
          contador_d = 2'd0;
          estado_d   = CALCULA;
        end
      end
      CALCULA: begin
        dados_d    = dados_misturados;
        contador_d = soma_contador[1:0];
        if (soma_contador[2]) begin
          estado_d = ENTREGA;
        end
      end
      ENTREGA: begin
        if (saida_pronta) begin
          estado_d = OCIOSO;
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_comb begin
    entrada_pronta = (estado_q == OCIOSO);
    saida_valida   = (estado_q == ENTREGA);
    ocupado        = (estado_q == CALCULA) || (estado_q == ENTREGA);
  end

  assign saida = dados_q;

endmodule
